// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   WIDTH-bit add/subtract computed one nibble per clock through a single
//   4-bit ripple-carry slice, LSB nibble first, with a registered carry.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : request pulse, sampled only while idle
//   sub    : 0 = add, 1 = subtract (captured at start)
//   a, b   : operands (captured at start)
//   cin    : carry-in for add, ignored for subtract
//   busy   : operation in flight
//   done   : one-cycle pulse, result valid
//   sum    : result register
//   cout   : final carry out (subtract: 1 = no borrow)
//   ovf    : signed overflow
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s;
  logic [4:0]       w_c;

  // Nibble select by shifting the latched operands down by 4*k.
  always_comb begin
    w_a_sh  = r_a >> {r_k, 2'b00};
    w_b_sh  = r_b >> {r_k, 2'b00};
    w_a_nib = w_a_sh[3:0];
    w_b_nib = w_b_sh[3:0] ^ {4{r_sub}};
    w_s     = '0;
    w_c     = '0;
    w_c[0]  = r_carry;
    for (int unsigned i = 0; i < 4; i++) begin
      w_s[i]   = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
      w_c[i+1] = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end
  end

  // done is registered on the DONE->IDLE edge, so it is visible while the
  // FSM is already idle; the next start is accepted on the edge after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : cin;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned n = 0; n < NIB; n++) begin
            if (r_k == KW'(n)) r_sum[4*n +: 4] <= w_s;
          end
          r_carry <= w_c[4];
          if (r_k == KW'(NIB - 1)) begin
            r_cout  <= w_c[4];
            r_ovf   <= w_c[3] ^ w_c[4];
            r_k     <= '0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH = 16).
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        scr;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full operation: accept, count edges to done, compare result.
  task automatic do_op(input vec_t v);
    int edges;
    int busy_cnt;
    bit got;
    @(negedge clk);
    sub = v.sub; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; busy_cnt = 0; got = 0;
    if (busy) busy_cnt++;
    while (!got && edges < 20) begin
      if (v.scr) begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", edges, 32'd5);
    check("busy_cycles", busy_cnt, 32'd5);
    check("sum", 32'(sum), 32'(v.s));
    check("cout", 32'(cout), 32'(v.co));
    check("ovf", 32'(ovf), 32'(v.ov));
    @(posedge clk); #1;
    check("done_width", 32'(done), 32'd0);
    check("sum_hold", 32'(sum), 32'(v.s));
  endtask

  initial begin
    int ndone;
    int cyc;
    int dcyc[3];
    vec_t v;

    //            sub a        b        cin scr  sum      co ov
    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // start pulsed during the 2nd RUN cycle must be ignored
    @(negedge clk);
    sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int e = 3; e <= 16; e++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("ign_done_edge", e, 32'd5);
        check("ign_sum", 32'(sum), 32'h3333);
      end
    end
    check("ign_done_count", ndone, 32'd1);
    check("ign_idle", 32'(busy), 32'd0);

    // start held high: three back-to-back operations
    @(negedge clk);
    sub = 1'b0; a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    cyc = -1; ndone = 0;
    while (ndone < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dcyc[ndone] = cyc;
        ndone++;
        check("b2b_sum", 32'(sum), 32'h0003);
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 32'd3);
    check("b2b_first", dcyc[0], 32'd5);
    check("b2b_space1", dcyc[1] - dcyc[0], 32'd6);
    check("b2b_space2", dcyc[2] - dcyc[1], 32'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_stop", 32'(busy), 32'd0);

    // async reset in the 3rd RUN cycle
    @(negedge clk);
    sub = 1'b0; a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("arst_no_done", ndone, 32'd0);
    v = '{1'b1, 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h3210, 1'b1, 1'b0};
    do_op(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
